// File: rtl/song_reader_if.sv
// Bundle of the play controls, song ROM port and note-player load/done
// handshake seen by song_reader. The master side is the sequencer.
interface song_reader_if #(
    parameter int SONG_BITS     = 2,
    parameter int NOTE_IDX_BITS = 5
);
    logic                               play;
    logic [SONG_BITS-1:0]               song;
    logic                               note_done;
    logic [SONG_BITS+NOTE_IDX_BITS-1:0] rom_addr;
    logic [11:0]                        rom_data;
    logic [5:0]                         note;
    logic [5:0]                         duration;
    logic                               new_note;
    logic                               song_done;

    modport master (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_reader.sv
// Walks the selected song in the song ROM and hands each note to the note
// player with a one-cycle new_note strobe, waiting for note_done in between.
module song_reader #(
    parameter int SONG_BITS     = 2,
    parameter int NOTE_IDX_BITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        WAIT,
        END,
        HALT
    } state_t;

    localparam logic [NOTE_IDX_BITS-1:0] LAST_IDX = '1;

    state_t                   state_reg, state_next;
    logic [NOTE_IDX_BITS-1:0] note_index_reg, note_index_next;
    logic [SONG_BITS-1:0]     song_q_reg, song_q_next;
    logic [5:0]               note_reg, note_next;
    logic [5:0]               duration_reg, duration_next;
    logic                     new_note_reg, new_note_next;
    logic                     song_done_reg, song_done_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            note_index_reg <= '0;
            song_q_reg     <= '0;
            note_reg       <= '0;
            duration_reg   <= '0;
            new_note_reg   <= 1'b0;
            song_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            note_index_reg <= note_index_next;
            song_q_reg     <= song_q_next;
            note_reg       <= note_next;
            duration_reg   <= duration_next;
            new_note_reg   <= new_note_next;
            song_done_reg  <= song_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        note_index_next = note_index_reg;
        song_q_next     = song_q_reg;
        note_next       = note_reg;
        duration_next   = duration_reg;
        new_note_next   = 1'b0;
        song_done_next  = 1'b0;

        // A new song selection abandons the current one silently; song_q is
        // picked up again once back in IDLE.
        if (state_reg != IDLE && bus.song != song_q_reg) begin
            state_next      = IDLE;
            note_index_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    song_q_next = bus.song;
                    if (bus.play) state_next = FETCH;
                end
                FETCH: begin
                    if (bus.play) state_next = DATA;
                end
                DATA: begin
                    if (bus.play) begin
                        if (bus.rom_data[5:0] == 6'd0) begin
                            state_next     = END;
                            song_done_next = 1'b1;
                        end else begin
                            note_next     = bus.rom_data[11:6];
                            duration_next = bus.rom_data[5:0];
                            new_note_next = 1'b1;
                            state_next    = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.note_done) begin
                        if (note_index_reg == LAST_IDX) begin
                            state_next     = END;
                            song_done_next = 1'b1;
                        end else begin
                            note_index_next = note_index_reg + 1'b1;
                            state_next      = FETCH;
                        end
                    end
                end
                END: begin
                    note_index_next = '0;
                    state_next      = HALT;
                end
                HALT: begin
                    // Require play to drop so a held play does not loop the song.
                    if (!bus.play) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.rom_addr  = {song_q_reg, note_index_reg};
    assign bus.note      = note_reg;
    assign bus.duration  = duration_reg;
    assign bus.new_note  = new_note_reg;
    assign bus.song_done = song_done_reg;
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a synchronous ROM model, a note-player responder and a
// song-level expectation list built straight from the ROM contents.
`timescale 1ns/1ps
module tb_song_reader;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] rom [128];

    song_reader_if bus ();

    song_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic load_basic();
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd20, 6'd8};
        rom[2] = {6'd33, 6'd0};
    endtask

    task automatic fill_random(input int s, input int len);
        logic [6:0] a;
        for (int i = 0; i < 32; i++) begin
            a = 7'(s * 32 + i);
            if (i < len)       rom[a] = {6'($urandom), 6'($urandom_range(1, 63))};
            else if (i == len) rom[a] = {6'($urandom), 6'd0};
            else               rom[a] = 12'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bus.play = 1'b0; bus.note_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Plays song s from IDLE/HALT, answering each note dly cycles later
    // (random when dly is 0), then holds play high for hold cycles.
    task automatic run_song(input int s, input int dly, input int hold, input string tag);
        logic [11:0] exp_q[$];
        logic [6:0]  a;
        int cyc, got, nn_at, sd_at, sd_cnt, done_at, last_sd;
        for (int i = 0; i < 32; i++) begin
            a = 7'(s * 32 + i);
            if (rom[a][5:0] == 6'd0) break;
            exp_q.push_back(rom[a]);
        end
        @(negedge clk);
        bus.song = 2'(s); bus.play = 1'b0; bus.note_done = 1'b0;
        @(negedge clk);
        bus.play = 1'b1;
        cyc = 0; got = 0; sd_cnt = 0; done_at = -1; last_sd = 0;
        nn_at = (exp_q.size() > 0) ? 3 : -1;
        sd_at = (exp_q.size() > 0) ? -1 : 3;
        while (cyc < 2000 && (sd_cnt == 0 || cyc < last_sd + hold)) begin
            @(negedge clk);
            cyc++;
            bus.note_done = 1'b0;
            if (bus.new_note) begin
                checks++;
                if (cyc != nn_at || got >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s new_note_timing: strobe at cycle %0d as note %0d, required cycle %0d of a %0d-note song",
                             tag, cyc, got, nn_at, exp_q.size());
                end else begin
                    checks++;
                    if ({bus.note, bus.duration} !== exp_q[got] || bus.rom_addr !== 7'(s * 32 + got)) begin
                        errors++;
                        $display("FAIL %s note_value: got note=%0d dur=%0d addr=%h, required note=%0d dur=%0d addr=%h",
                                 tag, bus.note, bus.duration, bus.rom_addr,
                                 exp_q[got][11:6], exp_q[got][5:0], 7'(s * 32 + got));
                    end
                end
                $display("%s song %0d idx %0d: note=%0d dur=%0d cycle=%0d", tag, s, got, bus.note, bus.duration, cyc);
                got++;
                nn_at = -1;
                done_at = cyc + ((dly > 0) ? dly : int'($urandom_range(1, 6)));
            end
            if (bus.song_done) begin
                checks++;
                if (cyc != sd_at) begin
                    errors++;
                    $display("FAIL %s song_done_timing: pulse at cycle %0d, required at %0d", tag, cyc, sd_at);
                end
                sd_cnt++;
                sd_at = -1;
                last_sd = cyc;
            end
            if (cyc == done_at) begin
                bus.note_done = 1'b1;
                if (got < exp_q.size()) nn_at = cyc + 3;
                else                    sd_at = cyc + ((got == 32) ? 1 : 3);
            end
        end
        bus.note_done = 1'b0;
        checks++;
        if (sd_cnt != 1 || got != exp_q.size()) begin
            errors++;
            $display("FAIL %s song_end: %0d notes and %0d song_done pulses, required %0d notes and 1 pulse",
                     tag, got, sd_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.play = 1'b0; bus.song = 2'd0; bus.note_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.new_note, bus.song_done, bus.note, bus.duration, bus.rom_addr} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: nn=%b sd=%b note=%0d dur=%0d addr=%h, required all 0",
                     bus.new_note, bus.song_done, bus.note, bus.duration, bus.rom_addr);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.rom_addr !== 7'd0) begin
                errors++;
                $display("FAIL reset_release_idle: nn=%b sd=%b addr=%h, required 0 0 00",
                         bus.new_note, bus.song_done, bus.rom_addr);
            end
        end
    endtask

    task automatic test_basic();
        load_basic();
        do_reset();
        run_song(0, 5, 20, "basic");
        run_song(0, 5, 4, "basic_replay");
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) rom[7'(32 + i)] = {6'($urandom), 6'd1};
        do_reset();
        run_song(1, 0, 10, "full");
        run_song(1, 0, 3, "full_replay");
    endtask

    // where: 0 pauses in FETCH, 1 in DATA, 2 in WAIT.
    task automatic test_pause(input int where);
        int cyc, nn_cnt, exp_at, pstart;
        fill_random(3, 32);
        do_reset();
        bus.song = 2'd3;
        @(negedge clk);
        bus.play = 1'b1;
        cyc = 0; nn_cnt = 0;
        pstart = (where == 2) ? 4 : where + 1;
        exp_at = (where == 2) ? 3 : 13;
        while (cyc < 24) begin
            @(negedge clk);
            cyc++;
            bus.note_done = 1'b0;
            if (bus.new_note) begin
                checks++;
                if (cyc != exp_at || nn_cnt > 1) begin
                    errors++;
                    $display("FAIL pause%0d new_note_timing: strobe at cycle %0d, required at %0d", where, cyc, exp_at);
                end else begin
                    checks++;
                    if ({bus.note, bus.duration} !== rom[7'(96 + nn_cnt)] || bus.rom_addr !== 7'(96 + nn_cnt)) begin
                        errors++;
                        $display("FAIL pause%0d note_value: got %h addr %h, required %h addr %h",
                                 where, {bus.note, bus.duration}, bus.rom_addr, rom[7'(96 + nn_cnt)], 7'(96 + nn_cnt));
                    end
                end
                $display("pause%0d new_note %0d: note=%0d dur=%0d cycle=%0d", where, nn_cnt, bus.note, bus.duration, cyc);
                nn_cnt++;
                exp_at = -1;
            end
            if (cyc <= pstart + 10) begin
                checks++;
                if (bus.rom_addr !== 7'h60) begin
                    errors++;
                    $display("FAIL pause%0d rom_addr_stable: got %h at cycle %0d, required 60", where, bus.rom_addr, cyc);
                end
            end
            if (cyc == pstart)      bus.play = 1'b0;
            if (cyc == pstart + 10) bus.play = 1'b1;
            if (where == 2 && cyc == 16) begin
                bus.note_done = 1'b1;
                exp_at = 19;
            end
        end
        bus.note_done = 1'b0;
        checks++;
        if (nn_cnt != ((where == 2) ? 2 : 1)) begin
            errors++;
            $display("FAIL pause%0d new_note_count: got %0d, required %0d", where, nn_cnt, (where == 2) ? 2 : 1);
        end
    endtask

    task automatic test_song_change();
        int cyc, nn, done_at, chg_at, chg, fin, sd_seen;
        fill_random(0, 12);
        fill_random(2, 32);
        do_reset();
        bus.song = 2'd0;
        @(negedge clk);
        bus.play = 1'b1;
        cyc = 0; nn = 0; done_at = -1; chg_at = -1; chg = -1; fin = 0; sd_seen = 0;
        while (cyc < 300 && fin == 0) begin
            @(negedge clk);
            cyc++;
            bus.note_done = 1'b0;
            if (bus.song_done) sd_seen++;
            if (bus.new_note) begin
                if (chg < 0) begin
                    nn++;
                    if (nn == 6) begin
                        chg_at = cyc + 2;
                        checks++;
                        if (bus.rom_addr !== 7'd5) begin
                            errors++;
                            $display("FAIL song_change setup_addr: got %h, required 05", bus.rom_addr);
                        end
                    end else begin
                        done_at = cyc + int'($urandom_range(1, 4));
                    end
                end else begin
                    checks++;
                    if (cyc != chg + 4 || bus.rom_addr !== 7'h40 || {bus.note, bus.duration} !== rom[64]) begin
                        errors++;
                        $display("FAIL song_change new_note: cycle %0d addr %h data %h, required cycle %0d addr 40 data %h",
                                 cyc, bus.rom_addr, {bus.note, bus.duration}, chg + 4, rom[64]);
                    end
                    $display("song_change new_note: note=%0d dur=%0d addr=%h", bus.note, bus.duration, bus.rom_addr);
                    fin = 1;
                end
            end
            if (cyc == done_at) bus.note_done = 1'b1;
            if (cyc == chg_at) begin
                bus.song = 2'd2;
                bus.note_done = 1'b1;
                chg = cyc;
            end
        end
        bus.note_done = 1'b0;
        checks++;
        if (fin != 1 || sd_seen != 0) begin
            errors++;
            $display("FAIL song_change outcome: restarted=%0d song_done_pulses=%0d, required 1 and 0", fin, sd_seen);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, done_at, found;
        load_basic();
        do_reset();
        bus.song = 2'd0;
        @(negedge clk);
        bus.play = 1'b1;
        cyc = 0; done_at = -1; found = 0;
        while (cyc < 100 && found == 0) begin
            @(negedge clk);
            cyc++;
            bus.note_done = 1'b0;
            if (bus.new_note && bus.note == 6'd20) found = 1;
            else begin
                if (bus.new_note) done_at = cyc + 5;
                if (cyc == done_at) bus.note_done = 1'b1;
            end
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL reset_mid setup: note 20 strobe seen=%0d, required 1", found);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.new_note, bus.song_done, bus.note, bus.duration, bus.rom_addr} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid async_clear: nn=%b sd=%b note=%0d dur=%0d addr=%h, required all 0",
                     bus.new_note, bus.song_done, bus.note, bus.duration, bus.rom_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        found = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.new_note) begin
                found++;
                checks++;
                if (c != 3 || bus.note !== 6'd10 || bus.duration !== 6'd4 || bus.rom_addr !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_mid restart: cycle %0d note=%0d dur=%0d addr=%h, required cycle 3 note=10 dur=4 addr=00",
                             c, bus.note, bus.duration, bus.rom_addr);
                end
                $display("reset_mid restart new_note: note=%0d dur=%0d", bus.note, bus.duration);
            end
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL reset_mid restart_count: %0d strobes, required 1", found);
        end
    endtask

    task automatic test_spurious();
        load_basic();
        do_reset();
        bus.song = 2'd0;
        // IDLE
        @(negedge clk); bus.note_done = 1'b1;
        @(negedge clk); bus.note_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.rom_addr !== 7'd0) begin
                errors++;
                $display("FAIL spurious_idle: nn=%b sd=%b addr=%h, required 0 0 00", bus.new_note, bus.song_done, bus.rom_addr);
            end
        end
        // FETCH, held there with play low
        bus.play = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.new_note !== (c == 8) || bus.song_done !== 1'b0 ||
                (c == 8 && ({bus.note, bus.duration} !== {6'd10, 6'd4} || bus.rom_addr !== 7'd0))) begin
                errors++;
                $display("FAIL spurious_fetch: cycle %0d nn=%b sd=%b note=%0d addr=%h, required strobe only at 8 with note 10 addr 00",
                         c, bus.new_note, bus.song_done, bus.note, bus.rom_addr);
            end
            bus.note_done = (c == 1);
            if (c == 1) bus.play = 1'b0;
            if (c == 6) bus.play = 1'b1;
        end
        // HALT
        do_reset();
        run_song(0, 3, 2, "spur_halt");
        @(negedge clk); bus.note_done = 1'b1;
        @(negedge clk); bus.note_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.rom_addr !== 7'd0) begin
                errors++;
                $display("FAIL spurious_halt: nn=%b sd=%b addr=%h, required 0 0 00", bus.new_note, bus.song_done, bus.rom_addr);
            end
        end
        run_song(0, 2, 2, "spur_replay");
    endtask

    task automatic test_random();
        int s, len;
        for (int it = 0; it < 6; it++) begin
            s = int'($urandom_range(2, 3));
            len = int'($urandom_range(0, 32));
            fill_random(s, len);
            run_song(s, 0, 4, "rand");
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.play = 1'b0;
        bus.song = 2'd0;
        bus.note_done = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 12'($urandom);
        load_basic();
        test_reset();
        test_basic();
        test_full();
        test_pause(0);
        test_pause(1);
        test_pause(2);
        test_song_change();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/song_reader.md
# song_reader

Sequencer on the producer side of the note load/done handshake. Walks the song ROM for the selected song, one note at a time. Presents each note code and duration to the note player with a one-cycle `new_note` strobe, then waits for the player's done indication before fetching the next entry. Sits between the top-level play/song controls and the note player.

## Interface

- `SONG_BITS`, default 2: song-select width (4 songs).
- `NOTE_IDX_BITS`, default 5: notes per song = 2^5 = 32.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `play`  in  1  level; 1 = advance through the song, 0 = pause/hold.
- `song`  in  2  song select; becomes ROM address high bits.
- `note_done`  in  1  from the note player; current note has finished.
- `rom_addr`  out  7  `{song_q, note_index}` to the song ROM.
- `rom_data`  in  12  `{note[11:6], duration[5:0]}`; synchronous ROM, valid one cycle after `rom_addr`.
- `note`  out  6  note code to load; registered.
- `duration`  out  6  duration to load, in beats; registered.
- `new_note`  out  1  one-cycle strobe; `note` and `duration` are valid while it is high.
- `song_done`  out  1  one-cycle strobe at end of song.

## Operation

- Internal registers:
  - `state`.
  - `note_index[4:0]`.
  - `song_q[1:0]`.
- States:
  - IDLE
  - FETCH
  - DATA
  - WAIT
  - END
  - HALT
- Reset (`reset`=0, asynchronous): state=IDLE, `note_index`=0, `song_q`=0, `note`=0, `duration`=0, `new_note`=0, `song_done`=0. `rom_addr` therefore resets to 0.
- IDLE:
  - `song_q`<=`song` every cycle.
  - `play`=1 -> FETCH.
- FETCH: address is stable this cycle. `play`=1 -> DATA; else stay.
- DATA: `rom_data` is valid.
  - `play`=0: stay.
  - Duration field = 0: end-of-song marker -> END. No `new_note`.
  - Otherwise: register note/duration, assert `new_note` next cycle -> WAIT.
- WAIT:
  - `note_done`=1 and `note_index`=31 -> END.
  - `note_done`=1 otherwise -> `note_index`+1, then FETCH.
  - `note_done` is sampled regardless of `play`, because the player only finishes while playing.
- END:
  - `song_done`=1 for exactly this cycle.
  - `note_index`<=0, then -> HALT.
- HALT: hold until `play`=0, then -> IDLE. A held-high `play` must not replay the song.
- Song change: `song`!=`song_q` in any state other than IDLE -> IDLE next cycle with `note_index`=0, no `song_done`.
- `note_done` outside WAIT is ignored.
- `note`/`duration` hold their last loaded value until the next load. Reset clears them.
- Priority when events coincide on one edge: `reset` > song change > `note_done`/`play` transitions.

## Timing

- `play` rises in IDLE, sampled at edge k:
  - FETCH after edge k.
  - DATA after k+1.
  - `new_note`=1 after k+2, with `note`/`duration` valid in the same cycle.
  - `new_note`=0 after k+3.
- `note_done` sampled at edge m in WAIT: FETCH after m, DATA after m+1, next `new_note` after m+2.
- Note-to-note gap is 3 cycles plus the player's duration.
- `new_note` is never high for two consecutive cycles.
- At most one `new_note` per `note_done`.
- `song_done` is high in the cycle after leaving the terminating WAIT/DATA state, for 1 cycle only.
- `rom_addr` changes only at edges where `note_index` or `song_q` change.
- `rom_addr` is held constant throughout FETCH/DATA, including while paused.
- Reset asserted mid-WAIT: all outputs are 0 immediately, without waiting for a clock edge.
- Reset release: first action is an IDLE->FETCH transition on the first edge with `play`=1.

## Test plan

- **Basic song.** ROM song 0 = (n=10,d=4),(n=20,d=8), then d=0. `play`=1; bench answers `note_done` 5 cycles after each `new_note`. Required:
  - `new_note` 3 edges after `play`, with `note`=10, `duration`=4.
  - Then `note`=20, `duration`=8.
  - One `song_done` pulse, then HALT.
  - No further `new_note` until `play` toggles 0->1, which replays from note 10.
- **Full song.** Song 1 has 32 entries, all d=1. Required:
  - 32 `new_note` pulses.
  - `rom_addr` goes 0x20 to 0x3F.
  - `song_done` follows the 32nd `note_done`; `note_index` wraps to 0.
- **Pause.** `play`=0 during FETCH, DATA and WAIT, for 10 cycles each. Required:
  - No state advance and no `new_note` during the pause.
  - `rom_addr` stable.
  - Resume yields exactly one `new_note` with the correct values.
- **Song change.** In WAIT on song 0 note 5, set `song`=2. Required:
  - IDLE next cycle; no `song_done`.
  - The next `new_note` carries entry `rom_addr`=0x40.
  - A simultaneous `note_done` is ignored.
- **Reset mid-operation.** Drop `reset` while `new_note`=1 and `note`=20. Required:
  - `new_note`, `note` and `duration` are 0 before the next clock edge.
  - After release with `play`=1, playback restarts at note index 0.
- **Spurious done.** Pulse `note_done` in IDLE, FETCH and HALT. Required: no state change, no output pulse.
